// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the multi-layer repeat sequencer.
package layer_seq_pkg;

    // Width used by the helper functions; callers zero-extend narrower values into it.
    localparam int unsigned CALC_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // True when rep_cnt is the final repeat of a layer programmed with cnt.
    // A programmed count of 0 behaves as 1. The compare is done without wrap.
    function automatic logic eff_last(input logic [CALC_W-1:0] cnt,
                                      input logic [CALC_W-1:0] rep_cnt);
        logic [CALC_W-1:0] eff;
        eff = (cnt == '0) ? CALC_W'(1) : cnt;
        return (rep_cnt == (eff - CALC_W'(1)));
    endfunction

    // Number of layers actually used: 0 becomes 1, anything above depth becomes depth.
    function automatic logic [CALC_W-1:0] clamp_layers(input logic [CALC_W-1:0] n,
                                                       input logic [CALC_W-1:0] depth);
        logic [CALC_W-1:0] r;
        if (n == '0) begin
            r = CALC_W'(1);
        end else if (n > depth) begin
            r = depth;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control, layer-table and channel-event bundle between trigger logic and the sequencer.
interface layer_sequencer_if #(
    parameter int unsigned CH    = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic                   io_start;
    logic                   io_abort;
    logic                   io_loop;
    logic [IDX_W:0]         io_numLayers;
    logic [DEPTH*CNT_W-1:0] io_layerCntTbl;
    logic [DEPTH*CH-1:0]    io_layerCfgTbl;
    logic [DEPTH-1:0]       io_modeTbl;
    logic [DEPTH-1:0]       io_baseTbl;
    logic [CH-1:0]          io_fbCatch;
    logic [CH-1:0]          io_delayEnd;
    logic [CH-1:0]          io_switchEnLogic;

    logic                   io_busy;
    logic [IDX_W-1:0]       io_layerIdx;
    logic [CNT_W-1:0]       io_repeatCnt;
    logic                   io_layerLast;
    logic                   io_layerEnd;
    logic                   io_seqEnd;
    logic                   io_aborted;

    // Controller / trigger side.
    modport master (
        output io_start, io_abort, io_loop, io_numLayers,
               io_layerCntTbl, io_layerCfgTbl, io_modeTbl, io_baseTbl,
               io_fbCatch, io_delayEnd, io_switchEnLogic,
        input  io_busy, io_layerIdx, io_repeatCnt, io_layerLast,
               io_layerEnd, io_seqEnd, io_aborted
    );

    // Sequencer side.
    modport slave (
        input  io_start, io_abort, io_loop, io_numLayers,
               io_layerCntTbl, io_layerCfgTbl, io_modeTbl, io_baseTbl,
               io_fbCatch, io_delayEnd, io_switchEnLogic,
        output io_busy, io_layerIdx, io_repeatCnt, io_layerLast,
               io_layerEnd, io_seqEnd, io_aborted
    );

endinterface

// File: rtl/layer_trig_sel.sv
// Selects the advancing event for one layer from the three channel event vectors.
module layer_trig_sel #(
    parameter int unsigned CH = 8
) (
    input  logic [CH-1:0] cfg,
    input  logic          mode,
    input  logic          base,
    input  logic [CH-1:0] fb_catch,
    input  logic [CH-1:0] delay_end,
    input  logic [CH-1:0] switch_en,
    output logic          trig_c
);

    // Base layers follow switch enable; others follow delay end or feedback catch by mode.
    always_comb begin
        trig_c = 1'b0;
        if (base) begin
            trig_c = |(switch_en & cfg);
        end else if (mode) begin
            trig_c = |(delay_end & cfg);
        end else begin
            trig_c = |(fb_catch & cfg);
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Multi-layer repeat sequencer: counts per-layer trigger events through a layer table.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int unsigned CH    = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input logic              io_clk,
    input logic              io_rst,
    layer_sequencer_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned NL_W  = IDX_W + 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             loop_q, loop_d;
    logic [NL_W-1:0]  nl_q, nl_d;
    logic             layer_end_q, layer_end_d;
    logic             seq_end_q, seq_end_d;
    logic             aborted_q, aborted_d;

    logic [CNT_W-1:0] cnt_sel_c;
    logic [CH-1:0]    cfg_sel_c;
    logic             mode_sel_c;
    logic             base_sel_c;
    logic             trig_c;
    logic             last_c;
    logic             last_layer_c;
    logic [NL_W-1:0]  nl_clamped_c;

    // Table slice for the current layer.
    always_comb begin
        cnt_sel_c  = bus.io_layerCntTbl[int'(idx_q)*CNT_W +: CNT_W];
        cfg_sel_c  = bus.io_layerCfgTbl[int'(idx_q)*CH +: CH];
        mode_sel_c = bus.io_modeTbl[idx_q];
        base_sel_c = bus.io_baseTbl[idx_q];
    end

    layer_trig_sel #(.CH(CH)) u_trig_sel (
        .cfg       (cfg_sel_c),
        .mode      (mode_sel_c),
        .base      (base_sel_c),
        .fb_catch  (bus.io_fbCatch),
        .delay_end (bus.io_delayEnd),
        .switch_en (bus.io_switchEnLogic),
        .trig_c    (trig_c)
    );

    // Last-repeat and last-layer qualifiers, plus the layer count to latch at start.
    always_comb begin
        last_c       = eff_last(CALC_W'(cnt_sel_c), CALC_W'(rep_q));
        last_layer_c = (NL_W'(idx_q) == (nl_q - NL_W'(1)));
        nl_clamped_c = NL_W'(clamp_layers(CALC_W'(bus.io_numLayers), CALC_W'(DEPTH)));
    end

    // State and datapath registers.
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rep_q       <= '0;
            loop_q      <= 1'b0;
            nl_q        <= NL_W'(1);
            layer_end_q <= 1'b0;
            seq_end_q   <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rep_q       <= rep_d;
            loop_q      <= loop_d;
            nl_q        <= nl_d;
            layer_end_q <= layer_end_d;
            seq_end_q   <= seq_end_d;
            aborted_q   <= aborted_d;
        end
    end

    // Next state, counters and pulses; abort takes priority over a same-cycle trigger.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rep_d       = rep_q;
        loop_d      = loop_q;
        nl_d        = nl_q;
        layer_end_d = 1'b0;
        seq_end_d   = 1'b0;
        aborted_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                rep_d = '0;
                if (bus.io_start && !bus.io_abort) begin
                    state_d = RUN;
                    loop_d  = bus.io_loop;
                    nl_d    = nl_clamped_c;
                end
            end
            RUN: begin
                if (bus.io_abort) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    rep_d     = '0;
                    aborted_d = 1'b1;
                end else if (trig_c) begin
                    if (!last_c) begin
                        rep_d = rep_q + CNT_W'(1);
                    end else begin
                        rep_d       = '0;
                        layer_end_d = 1'b1;
                        if (!last_layer_c) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else begin
                            seq_end_d = 1'b1;
                            idx_d     = '0;
                            if (!loop_q) begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output drive; layerLast is derived from registers and gated off in IDLE.
    assign bus.io_busy      = (state_q == RUN);
    assign bus.io_layerIdx  = idx_q;
    assign bus.io_repeatCnt = rep_q;
    assign bus.io_layerLast = (state_q == RUN) && last_c;
    assign bus.io_layerEnd  = layer_end_q;
    assign bus.io_seqEnd    = seq_end_q;
    assign bus.io_aborted   = aborted_q;

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Parametrised multi-layer successor of the single-layer repeat counter. It steps through a table of up to DEPTH layers. Each layer repeats a programmed number of times, advancing on a per-layer selection of channel events: feedback catch, delay end, or base-layer switch enable. It sits between the per-channel trigger logic and the scan controller. It adds start/abort control, sequence looping and registered end-of-layer and end-of-sequence pulses.

## Interface
- CH, 8: channel count; width of every event vector and layer mask.
- CNT_W, 16: repeat-count width.
- DEPTH, 4: layer-table entries (≥2); IDX_W = $clog2(DEPTH).
- io_clk  in  1  clock.
- io_rst  in  1  reset; asynchronous, active-high.
- io_start  in  1  start sequence (honoured in IDLE only).
- io_abort  in  1  abort sequence (any state).
- io_loop  in  1  restart from layer 0 after last layer; latched at start.
- io_numLayers  in  IDX_W+1  layers used; 0 treated as 1, >DEPTH clamped to DEPTH; latched at start.
- io_layerCntTbl  in  DEPTH*CNT_W  repeat count per layer; entry k at [k*CNT_W +: CNT_W]; 0 treated as 1.
- io_layerCfgTbl  in  DEPTH*CH  channel mask per layer.
- io_modeTbl  in  DEPTH  per-layer working mode: 1 = delay end, 0 = feedback catch.
- io_baseTbl  in  DEPTH  per-layer base flag: 1 = trigger on switch enable.
- io_fbCatch, io_delayEnd, io_switchEnLogic  in  CH each  channel events, synchronous to io_clk.
- io_busy  out  1  high in RUN.
- io_layerIdx  out  IDX_W  current layer.
- io_repeatCnt  out  CNT_W  completed repeats in current layer.
- io_layerLast  out  1  current repeat is the layer's last (combinational from registers; low in IDLE).
- io_layerEnd  out  1  registered pulse: a layer completed.
- io_seqEnd  out  1  registered pulse: final layer completed.
- io_aborted  out  1  registered pulse: abort accepted while busy.

## Operation
- Trigger for layer k: if baseTbl[k], trig = |(switchEnLogic & cfgTbl[k]). Otherwise trig = |(cfgTbl[k] & (modeTbl[k] ? delayEnd : fbCatch)).
- last = (repeatCnt == effCnt-1), where effCnt = max(layerCntTbl[idx],1). Compare in CNT_W bits with no wrap.
- FSM states: IDLE, RUN.
- IDLE: idx=0, repeatCnt=0, and trigger events are ignored.
- IDLE with start & !abort: go to RUN; latch loop and the clamped numLayers.
- RUN with trig & !last: repeatCnt+1.
- RUN with trig & last: repeatCnt=0 and layerEnd pulses.
  - If idx < nL-1: idx+1.
  - Else seqEnd also pulses. With loop latched: idx=0, stay in RUN. Without loop: go to IDLE.
- RUN with abort: go to IDLE, idx=0, repeatCnt=0, aborted pulses. Abort beats a same-cycle trigger, so no layerEnd/seqEnd pulse is produced.
- io_start while in RUN is ignored.
- Tables must be static while busy. A table change mid-run is applied from the next cycle and has no defined effect on pulses already issued.
- Reset (any time, including mid-sequence): state IDLE, idx 0, repeatCnt 0, all pulses and busy low, latched loop 0, latched nL 1.

## Timing
- Event sampled at edge t. repeatCnt/idx update at edge t, and the layerEnd/seqEnd/aborted pulse is high for exactly the cycle after edge t.
- The pulse cycle shows the already-advanced idx/repeatCnt.
- Triggers on consecutive cycles each count; there is no dead cycle between layers.
- Start → busy high one cycle later. The first trigger is counted in the cycle busy is first high.
- Sequence end without loop → busy low in the same cycle seqEnd is high.

## Structure
- Package layer_seq_pkg holds:
  - the state enum {IDLE, RUN};
  - the function eff_last(cnt, repeat), which implements the 0→1 rule and the last compare;
  - the function clamp_layers(n).
- Sub-module layer_trig_sel (parameter CH): computes trig from cfg, mode, base and the three event vectors. One instance, fed by the current idx's table slice.

## Test plan
- CH=8, DEPTH=4, nL=2, cnt={3,2}, layer0 mode=1, cfg=0x01: five delayEnd[0] pulses. Required: layerEnd after the 3rd and 5th, seqEnd with the 5th, busy low after it.
- layer0 cfg=0x02, mode=0: fbCatch=0x01 → no count. fbCatch=0x02 → count. delayEnd=0x02 → no count.
- baseTbl[0]=1, cfg=0x80, cnt=0: a single switchEnLogic[7] pulse gives layerEnd and seqEnd (cnt 0 treated as 1).
- loop=1, nL=3, cnt=1 each, triggers held high: idx cycles 0,1,2,0 with layerEnd every cycle and seqEnd every 3rd; start pulses while in RUN are ignored.
- Abort and trigger in the same cycle at the last repeat: aborted pulses, no layerEnd, idx/repeatCnt read 0. io_rst asserted mid-run clears all outputs asynchronously.
- nL=7 with DEPTH=4 is clamped to 4 layers; nL=0 runs 1 layer.
